instr_mem: RTL and testbench

INSTR_MEM -- requirements
Module: instr_mem

---
 rtl/instr_mem.sv | 49 ++++
 tb/tb_instr_mem.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/instr_mem.sv
// Instruction memory: combinational word-indexed read port, synchronous program-load
// write port, and a sticky error flag for misaligned/out-of-range accesses.
module instr_mem #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH   = 32,
    parameter int MEM_DEPTH     = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    output logic [INSTR_WIDTH-1:0]   instr,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [INSTR_WIDTH-1:0]   wr_data,
    output logic                     misaligned,
    output logic                     out_of_range,
    output logic                     err_sticky
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    // One extra bit so 4*MEM_DEPTH cannot wrap for narrow address widths.
    localparam logic [ADDRESS_WIDTH:0] LIMIT = (ADDRESS_WIDTH+1)'(4 * MEM_DEPTH);
    localparam logic [INSTR_WIDTH-1:0] NOP   = INSTR_WIDTH'(32'h0000_0013);

    logic [INSTR_WIDTH-1:0] memory [0:MEM_DEPTH-1];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_oor;

    assign rd_idx       = addr[IDX_W+1:2];
    assign wr_idx       = wr_addr[IDX_W+1:2];
    assign misaligned   = (addr[1:0] != 2'b00);
    assign out_of_range = ({1'b0, addr} >= LIMIT);
    assign wr_oor       = ({1'b0, wr_addr} >= LIMIT);
    assign instr        = out_of_range ? NOP : memory[rd_idx];

    // No reset on the array so a preloaded program survives rst_n.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en && !wr_oor)
            memory[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            err_sticky <= 1'b0;
        else if (misaligned || out_of_range || (wr_en && wr_oor))
            err_sticky <= 1'b1;
    end
endmodule

// File: tb/tb_instr_mem.sv
// Directed bench for instr_mem: a word-array model tracks writes and the sticky flag,
// a negedge process compares against it, and directed steps pin literal values.
module tb_instr_mem;
    localparam int AW = 32;
    localparam int IW = 32;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    bit            clk_run = 1'b0;
    logic          rst_n;
    logic [AW-1:0] addr;
    logic [IW-1:0] instr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [IW-1:0] wr_data;
    logic          misaligned;
    logic          out_of_range;
    logic          err_sticky;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_mem [0:DEPTH-1];
    bit          m_known [0:DEPTH-1];
    bit          m_err = 1'b0;

    logic [31:0] prog [0:6];

    instr_mem #(.ADDRESS_WIDTH(AW), .INSTR_WIDTH(IW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .instr(instr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .misaligned(misaligned), .out_of_range(out_of_range), .err_sticky(err_sticky)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: spec rules in plain arithmetic on byte addresses.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_err = 1'b0;
        end else begin
            if ((addr % 4) != 0 || addr >= 4*DEPTH || (wr_en && wr_addr >= 4*DEPTH))
                m_err = 1'b1;
            if (wr_en && wr_addr < 4*DEPTH) begin
                m_mem[wr_addr / 4]   = wr_data;
                m_known[wr_addr / 4] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_misaligned", {31'b0, misaligned}, {31'b0, (addr % 4) != 0});
        chk("cmp_out_of_range", {31'b0, out_of_range}, {31'b0, addr >= 4*DEPTH});
        chk("cmp_err_sticky", {31'b0, err_sticky}, {31'b0, m_err});
        if (addr >= 4*DEPTH)
            chk("cmp_instr_nop", instr, 32'h0000_0013);
        else if (m_known[addr / 4])
            chk("cmp_instr", instr, m_mem[addr / 4]);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        prog[0] = 32'h00500093; prog[1] = 32'h00100113; prog[2] = 32'h002081B3;
        prog[3] = 32'h00010093; prog[4] = 32'h00018113; prog[5] = 32'hFE000AE3;
        prog[6] = 32'h00000073;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

        rst_n = 1'b0; addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        clk_run = 1'b1;
        step(); step();
        chk("reset_err", {31'b0, err_sticky}, 32'd0);
        rst_n = 1'b1;

        // Program load through the write port.
        for (int i = 0; i < 7; i++) begin
            wr_en = 1'b1; wr_addr = 32'(4 * i); wr_data = prog[i];
            step();
        end
        wr_en = 1'b0;

        // Combinational reads with the clock stopped.
        @(negedge clk);
        clk_run = 1'b0;
        begin
            logic [31:0] lit [0:5];
            lit[0] = 32'h00500093; lit[1] = 32'h00100113; lit[2] = 32'h002081B3;
            lit[3] = 32'h00010093; lit[4] = 32'h00018113; lit[5] = 32'hFE000AE3;
            for (int i = 0; i < 6; i++) begin
                addr = 32'(4 * i);
                #10;
                chk("read_word", instr, lit[i]);
                chk("read_aligned", {31'b0, misaligned}, 32'd0);
            end
        end
        addr = 32'd18; #10;
        chk("addr18_instr", instr, 32'h00018113);
        chk("addr18_misaligned", {31'b0, misaligned}, 32'd1);
        addr = 32'd24; #10;
        chk("addr24_instr", instr, 32'h00000073);
        chk("no_edge_no_err", {31'b0, err_sticky}, 32'd0);
        addr = 32'h400; #10;
        chk("oor_nop", instr, 32'h00000013);
        chk("oor_flag", {31'b0, out_of_range}, 32'd1);
        chk("oor_aligned", {31'b0, misaligned}, 32'd0);
        clk_run = 1'b1;
        step();
        chk("oor_err_set", {31'b0, err_sticky}, 32'd1);

        // Clear, then write 0x0D (lands in word 3) with read-during-write.
        rst_n = 1'b0; addr = '0; step();
        chk("reset_clears_err", {31'b0, err_sticky}, 32'd0);
        rst_n = 1'b1; step();
        addr = 32'd12; wr_en = 1'b1; wr_addr = 32'h0D; wr_data = 32'hDEADBEEF;
        #1;
        chk("rdw_old", instr, 32'h00010093);
        step();
        chk("rdw_new", instr, 32'hDEADBEEF);
        chk("unaligned_waddr_no_err", {31'b0, err_sticky}, 32'd0);
        wr_addr = 32'h400; wr_data = 32'h12345678;
        step();
        wr_en = 1'b0;
        chk("oor_write_word3", instr, 32'hDEADBEEF);
        chk("oor_write_err", {31'b0, err_sticky}, 32'd1);
        addr = 32'd0; #1;
        chk("oor_write_no_alias", instr, 32'h00500093);

        // Reset with a concurrent write: write ignored, memory kept.
        rst_n = 1'b0; wr_en = 1'b1; wr_addr = 32'd0; wr_data = 32'hFFFFFFFF;
        step();
        chk("rst_err_clear", {31'b0, err_sticky}, 32'd0);
        chk("rst_write_ignored", instr, 32'h00500093);
        wr_en = 1'b0;
        addr = 32'd20; #1;
        chk("rst_keeps_word5", instr, 32'hFE000AE3);
        chk("rst_comb_in_reset", {31'b0, misaligned}, 32'd0);
        rst_n = 1'b1;
        addr = 32'd2; step();
        chk("resume_err_capture", {31'b0, err_sticky}, 32'd1);
        addr = 32'd0; step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
